// File: rtl/mmio_console_tx_pkg.sv
// rtl/mmio_console_tx_pkg.sv - UART state encodings, register offsets and STATUS bit positions
package mmio_console_tx_pkg;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

   localparam logic [2:0] CON_TXDATA_OFS = 3'h0;
   localparam logic [2:0] CON_STATUS_OFS = 3'h4;

   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_BUSY_BIT  = 2;
   localparam int STAT_OVF_BIT   = 3;
   localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_pop_data,
   output logic                     o_push_ok,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign w_pop_ok  = i_pop && (r_count != '0);
   assign w_push_ok = i_push && ((r_count != FULL_CNT) || w_pop_ok);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once the count says they are valid.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_pop_data = r_mem[r_rd_ptr];
   assign o_push_ok  = w_push_ok;
   assign o_full     = (r_count == FULL_CNT);
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;

endmodule

// File: rtl/mmio_console_tx.sv
// rtl/mmio_console_tx.sv - memory-mapped TXDATA/STATUS window feeding a byte FIFO and a UART 8N1 sender
module mmio_console_tx
   import mmio_console_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   input  logic        i_mem_we,
   input  logic        i_mem_re,
   output logic        o_mem_hit,
   output logic [31:0] o_mem_rdata,
   output logic        o_uart_tx,
   output logic        o_tx_busy
);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = $clog2(CLKS_PER_BIT);
   localparam int LAST_CNT = CLKS_PER_BIT - 1;

   uart_state_t   r_state;
   logic [CW-1:0] r_bit_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          r_ovf;

   logic          w_hit;
   logic          w_sel_status;
   logic          w_push;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_ovf_clr;
   logic          w_full;
   logic          w_empty;
   logic [AW:0]   w_count;
   logic [7:0]    w_pop_data;
   logic          w_bit_end;
   logic          w_busy;
   logic [31:0]   w_status;
   logic [31:0]   w_rdata;
   logic          w_unused;

   assign w_hit        = (i_mem_addr[31:3] == BASE_ADDR[31:3]);
   assign w_sel_status = (i_mem_addr[2] == CON_STATUS_OFS[2]);
   assign w_push       = i_mem_we && w_hit && !w_sel_status;
   assign w_ovf_clr    = i_mem_we && w_hit && w_sel_status && i_mem_wdata[STAT_OVF_BIT];
   assign w_pop        = (r_state == UART_IDLE) && !w_empty;
   assign w_bit_end    = (r_bit_cnt == LAST_CNT[CW-1:0]);
   assign w_busy       = (r_state != UART_IDLE) || !w_empty;
   assign w_unused     = &{1'b0, i_mem_addr[1:0], i_mem_wdata[31:8]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (w_push),
      .i_push_data (i_mem_wdata[7:0]),
      .i_pop       (w_pop),
      .o_pop_data  (w_pop_data),
      .o_push_ok   (w_push_ok),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   // A rejected push sets ovf and outranks a clear arriving in the same cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                      r_ovf <= 1'b0;
      else if (w_push && !w_push_ok)  r_ovf <= 1'b1;
      else if (w_ovf_clr)             r_ovf <= 1'b0;
   end

   always_comb begin
      w_status = '0;
      w_status[STAT_FULL_BIT]  = w_full;
      w_status[STAT_EMPTY_BIT] = w_empty;
      w_status[STAT_BUSY_BIT]  = w_busy;
      w_status[STAT_OVF_BIT]   = r_ovf;
      w_status[STAT_COUNT_LSB +: AW+1] = w_count;
   end

   always_comb begin
      w_rdata = '0;
      if (i_mem_re && w_hit && w_sel_status) w_rdata = w_status;
   end

   // The line register follows the state one cycle late, so a frame starts two cycles after its push.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= UART_IDLE;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            UART_IDLE: begin
               r_tx <= 1'b1;
               if (!w_empty) begin
                  r_shift   <= w_pop_data;
                  r_bit_cnt <= '0;
                  r_bit_idx <= '0;
                  r_state   <= UART_START;
               end
            end
            UART_START: begin
               r_tx <= 1'b0;
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  r_state   <= UART_DATA;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            UART_DATA: begin
               r_tx <= r_shift[0];
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == 3'd7) r_state <= UART_STOP;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            UART_STOP: begin
               r_tx <= 1'b1;
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  r_state   <= UART_IDLE;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            default: r_state <= UART_IDLE;
         endcase
      end
   end

   assign o_mem_hit   = w_hit;
   assign o_mem_rdata = w_rdata;
   assign o_uart_tx   = r_tx;
   assign o_tx_busy   = w_busy;

endmodule
